// File: rtl/iter_log2_pkg.sv
// Shared types and default widths for the iterative log2/exp2 unit.
// Imported by the unit top.
package iter_log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOG  = 2'd1,
    EXP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int VW_DEF = 32;
  localparam int CW_DEF = 8;

endpackage

// File: rtl/iter_log2_exp2_unit.sv
// Iterative bit-length (LOG) and 1<<N (EXP), one shift per clock.
// Optional macro ITER_LOG2_EXP_CLAMP_EN clamps N to VW at accept.
module iter_log2_exp2_unit
  import iter_log2_pkg::*;
#(
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_value,
  input  logic [CW-1:0] in_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_log,
  output logic [VW-1:0] out_exp
);

  state_t        state_q;
  logic [VW-1:0] val_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] log_acc_q;
  logic [VW-1:0] exp_acc_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [CW-1:0] out_log_q;
  logic [VW-1:0] out_exp_q;
  logic [CW-1:0] cnt_init_d;

  // Shift count loaded at accept; shifts beyond VW change nothing
  always_comb begin
    cnt_init_d = in_shamt;
`ifdef ITER_LOG2_EXP_CLAMP_EN
    if (int'(in_shamt) > VW) begin
      cnt_init_d = CW'(VW);
    end
`else
`endif
  end

  // Control FSM with inlined shifters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      val_q       <= '0;
      cnt_q       <= '0;
      log_acc_q   <= '0;
      exp_acc_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_log_q   <= '0;
      out_exp_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            val_q      <= in_value;
            cnt_q      <= cnt_init_d;
            log_acc_q  <= '0;
            exp_acc_q  <= VW'(1);
            in_ready_q <= 1'b0;
            state_q    <= LOG;
          end
        end
        LOG: begin
          if (val_q != '0) begin
            val_q     <= val_q >> 1;
            log_acc_q <= log_acc_q + CW'(1);
          end else begin
            state_q <= EXP;
          end
        end
        EXP: begin
          if (cnt_q != '0) begin
            exp_acc_q <= {exp_acc_q[VW-2:0], 1'b0};
            cnt_q     <= cnt_q - CW'(1);
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_log_q   <= log_acc_q;
            out_exp_q   <= exp_acc_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_log   = out_log_q;
  assign out_exp   = out_exp_q;

endmodule

// File: tb/tb_iter_log2_exp2_unit.sv
// Scoreboard bench for iter_log2_exp2_unit: directed vectors,
// queue of expected results, separate output monitor.
module tb_iter_log2_exp2_unit;
  import iter_log2_pkg::*;

  localparam int VW = 32;
  localparam int CW = 8;

`ifdef ITER_LOG2_EXP_CLAMP_EN
  localparam int LAT_1_40  = 35;
  localparam int LAT_1_255 = 35;
`else
  localparam int LAT_1_40  = 43;
  localparam int LAT_1_255 = 258;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_value = '0;
  logic [CW-1:0] in_shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_log;
  logic [VW-1:0] out_exp;

  typedef struct {
    logic [CW-1:0] lg;
    logic [VW-1:0] ex;
    int            lat;
    int            bp;
    int            acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  iter_log2_exp2_unit #(.VW(VW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log   (out_log),
    .out_exp   (out_exp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send(logic [VW-1:0] v, logic [CW-1:0] n,
                      logic [CW-1:0] lg, logic [VW-1:0] ex,
                      int lat, int bp, bit push);
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid = 1'b1;
    in_value = v;
    in_shamt = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.lg = lg;
      e.ex = ex;
      e.lat = lat;
      e.bp = bp;
      e.acc = cyc;
      q.push_back(e);
    end
    chk("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Output monitor: compares each new result with the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !rst) begin
        if (q.size() == 0) begin
          chk("spurious_result", 64'd1, 64'd0);
          out_ready = 1'b1;
          @(posedge clk);
          #1 out_ready = 1'b0;
        end else begin
          e = q.pop_front();
          chk("out_log", 64'(out_log), 64'(e.lg));
          chk("out_exp", 64'(out_exp), 64'(e.ex));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          for (int i = 0; i < e.bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_log", 64'(out_log), 64'(e.lg));
            chk("bp_exp", 64'(out_exp), 64'(e.ex));
          end
          out_ready = 1'b1;
          @(posedge clk);
          #1 out_ready = 1'b0;
          @(negedge clk);
          chk("valid_drop", 64'(out_valid), 64'd0);
          chk("hold_log", 64'(out_log), 64'(e.lg));
          chk("hold_exp", 64'(out_exp), 64'(e.ex));
        end
      end
    end
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_log", 64'(out_log), 64'd0);
    chk("rst_out_exp", 64'(out_exp), 64'd0);
    rst = 1'b0;

    send(32'd0, 8'd0, 8'd0, 32'd1, 2, 0, 1'b1);
    send(32'd5, 8'd3, 8'd3, 32'd8, 8, 0, 1'b1);
    send(32'hFFFFFFFF, 8'd31, 8'd32, 32'h80000000, 65, 0, 1'b1);
    send(32'd1, 8'd40, 8'd1, 32'd0, LAT_1_40, 0, 1'b1);
    send(32'h80000000, 8'd0, 8'd32, 32'd1, 34, 0, 1'b1);
    send(32'd3, 8'd32, 8'd2, 32'd0, 36, 0, 1'b1);
    send(32'd1, 8'd255, 8'd1, 32'd0, LAT_1_255, 0, 1'b1);

    send(32'd6, 8'd4, 8'd3, 32'd16, 9, 5, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_wait", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'd7;
    in_shamt = 8'd1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;

    send(32'd255, 8'd0, 8'd0, 32'd0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("arst_idle_ready", 64'(in_ready), 64'd1);
    chk("arst_idle_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;

    send(32'd2, 8'd1, 8'd2, 32'd2, 5, 0, 1'b1);

    k = 0;
    while (q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("final_valid", 64'(out_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
